// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA/decrypt stage.
// The character helper defines the plaintext alphabet: lower-case letters and space.
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SET_I,
      ST_RD_SI,
      ST_LAT_SI,
      ST_RD_SJ,
      ST_LAT_SJ,
      ST_WR_SI,
      ST_WR_SJ,
      ST_RD_F,
      ST_LAT_F,
      ST_WR_DEC,
      ST_DONE,
      ST_FAIL
   } prga_state_e;

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;

   function automatic logic is_msg_char(input logic [7:0] c);
      return (c == CHAR_SPACE) || ((c >= CHAR_LO) && (c <= CHAR_HI));
   endfunction

endpackage

// File: rtl/prga_decrypt_fsm_if.sv
// Bus bundle between the PRGA/decrypt FSM (master) and its S memory, ROM, RAM and controller (slave).
interface prga_decrypt_fsm_if #(
   parameter int MSG_AW = 5
);
   logic              start;
   logic [7:0]        s_address;
   logic [7:0]        s_data;
   logic              s_wren;
   logic [7:0]        s_q;
   logic [MSG_AW-1:0] rom_address;
   logic [7:0]        rom_q;
   logic [MSG_AW-1:0] dec_address;
   logic [7:0]        dec_data;
   logic              dec_wren;
   logic              busy;
   logic              done;
   logic              key_valid;
   logic              key_invalid;

   modport master (
      input  start, s_q, rom_q,
      output s_address, s_data, s_wren, rom_address, dec_address, dec_data, dec_wren,
             busy, done, key_valid, key_invalid
   );

   modport slave (
      output start, s_q, rom_q,
      input  s_address, s_data, s_wren, rom_address, dec_address, dec_data, dec_wren,
             busy, done, key_valid, key_invalid
   );
endinterface

// File: rtl/rc4_char_check.sv
// Combinational plaintext check: high when the byte is 'a'..'z' or space.
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       char_valid
);

   assign char_valid = is_msg_char(char_in);

endmodule

// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA and decrypt stage: permutes S, XORs keystream with the encrypted ROM,
// writes plaintext to RAM and reports whether every byte is in the message alphabet.
module prga_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN     = 32,
   parameter int MSG_AW      = 5,
   parameter int EARLY_ABORT = 1
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   prga_decrypt_fsm_if.master bus
);

   localparam logic [MSG_AW-1:0] K_LAST   = MSG_AW'(MSG_LEN - 1);
   localparam bit                ABORT_EN = (EARLY_ABORT != 0);

   prga_state_e       state_q, state_d;
   logic [7:0]        i_q, i_d;
   logic [7:0]        j_q, j_d;
   logic [7:0]        si_q, si_d;
   logic [7:0]        sj_q, sj_d;
   logic [7:0]        f_q, f_d;
   logic [MSG_AW-1:0] k_q, k_d;
   logic              bad_q, bad_d;

   logic              f_valid;

   logic [7:0]        s_address_c;
   logic [7:0]        s_data_c;
   logic              s_wren_c;
   logic [MSG_AW-1:0] rom_address_c;
   logic [MSG_AW-1:0] dec_address_c;
   logic [7:0]        dec_data_c;
   logic              dec_wren_c;

   rc4_char_check u_char_check (
      .char_in    (f_q),
      .char_valid (f_valid)
   );

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         f_q     <= '0;
         k_q     <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         f_q     <= f_d;
         k_q     <= k_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      si_d          = si_q;
      sj_d          = sj_q;
      f_d           = f_q;
      k_d           = k_q;
      bad_d         = bad_q;
      s_address_c   = '0;
      s_data_c      = '0;
      s_wren_c      = 1'b0;
      rom_address_c = '0;
      dec_address_c = '0;
      dec_data_c    = '0;
      dec_wren_c    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (bus.start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               bad_d   = 1'b0;
               state_d = ST_SET_I;
            end
         end
         ST_SET_I: begin
            i_d     = i_q + 8'd1;
            state_d = ST_RD_SI;
         end
         ST_RD_SI: begin
            s_address_c = i_q;
            state_d     = ST_LAT_SI;
         end
         ST_LAT_SI: begin
            si_d    = bus.s_q;
            j_d     = j_q + bus.s_q;
            state_d = ST_RD_SJ;
         end
         ST_RD_SJ: begin
            s_address_c = j_q;
            state_d     = ST_LAT_SJ;
         end
         ST_LAT_SJ: begin
            sj_d    = bus.s_q;
            state_d = ST_WR_SI;
         end
         // Swap from the latched copies; when i==j the second write restores the same value.
         ST_WR_SI: begin
            s_address_c = i_q;
            s_data_c    = sj_q;
            s_wren_c    = 1'b1;
            state_d     = ST_WR_SJ;
         end
         ST_WR_SJ: begin
            s_address_c = j_q;
            s_data_c    = si_q;
            s_wren_c    = 1'b1;
            state_d     = ST_RD_F;
         end
         ST_RD_F: begin
            s_address_c   = si_q + sj_q;
            rom_address_c = k_q;
            state_d       = ST_LAT_F;
         end
         ST_LAT_F: begin
            f_d     = bus.s_q ^ bus.rom_q;
            state_d = ST_WR_DEC;
         end
         ST_WR_DEC: begin
            dec_address_c = k_q;
            dec_data_c    = f_q;
            dec_wren_c    = 1'b1;
            if (!f_valid) begin
               bad_d = 1'b1;
            end
            if (!f_valid && ABORT_EN) begin
               state_d = ST_FAIL;
            end else if (k_q == K_LAST) begin
               state_d = ST_DONE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = ST_SET_I;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.s_address   = s_address_c;
   assign bus.s_data      = s_data_c;
   assign bus.s_wren      = s_wren_c;
   assign bus.rom_address = rom_address_c;
   assign bus.dec_address = dec_address_c;
   assign bus.dec_data    = dec_data_c;
   assign bus.dec_wren    = dec_wren_c;
   assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_FAIL);
   assign bus.done        = (state_q == ST_DONE) || (state_q == ST_FAIL);
   assign bus.key_valid   = (state_q == ST_DONE) && !bad_q;
   assign bus.key_invalid = (state_q == ST_FAIL) || ((state_q == ST_DONE) && bad_q);

endmodule
